// File: rtl/soml_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soml_pkg
//  Description : Shared types and constants for the SOML STBC encoder:
//                amplitude levels for both scaling modes, the antenna-pair
//                lookup, the complex sample type and the FSM state codes.
//                Level selection is controlled by SOML_ENC_POWER_NORM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package soml_pkg;

    localparam int c_Q = 22;
    localparam int c_N = 32;

    // Unscaled Q22 levels for +1 and +3.
    localparam logic signed [31:0] c_LVL1_UNIT = 32'sd4194304;
    localparam logic signed [31:0] c_LVL3_UNIT = 32'sd12582912;
    // Power-normalised Q22 levels (2^22/sqrt(10) and three times that).
    localparam logic signed [31:0] c_LVL1_NORM = 32'sd1326355;
    localparam logic signed [31:0] c_LVL3_NORM = 32'sd3979065;

    typedef struct packed {
        logic signed [c_N-1:0] r;
        logic signed [c_N-1:0] i;
    } cplx_t;

    typedef struct packed {
        logic [1:0] ant_a;
        logic [1:0] ant_b;
    } pair_t;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_MAP  = 2'd1;
    localparam state_t c_ST_SEND = 2'd2;

    // Antenna pair addressed by the two top bits of the information word.
    function automatic pair_t pair_lookup(input logic [1:0] i_sel);
        pair_t w_p;
        case (i_sel)
            2'd0:    begin w_p.ant_a = 2'd0; w_p.ant_b = 2'd1; end
            2'd1:    begin w_p.ant_a = 2'd2; w_p.ant_b = 2'd3; end
            2'd2:    begin w_p.ant_a = 2'd0; w_p.ant_b = 2'd2; end
            default: begin w_p.ant_a = 2'd1; w_p.ant_b = 2'd3; end
        endcase
        return w_p;
    endfunction

    // Gray-coded PAM-4: 00->-3, 01->-1, 11->+1, 10->+3.
    function automatic logic signed [c_N-1:0] pam4_level(
        input logic [1:0]            i_b,
        input logic signed [c_N-1:0] i_l1,
        input logic signed [c_N-1:0] i_l3
    );
        logic signed [c_N-1:0] w_v;
        case (i_b)
            2'b00:   w_v = -i_l3;
            2'b01:   w_v = -i_l1;
            2'b11:   w_v = i_l1;
            default: w_v = i_l3;
        endcase
        return w_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soml_qam16_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : soml_qam16_mapper
//  Description : Combinational 16-QAM mapper: 4 bits {I[1:0], Q[1:0]} to a
//                complex fixed-point symbol with Q fractional bits.
//                SOML_ENC_POWER_NORM_EN selects the normalised levels.
//  Revision    : 1.0 - initial release
// ============================================================================
module soml_qam16_mapper
    import soml_pkg::*;
#(
    parameter int Q = c_Q
) (
    input  logic [3:0] i_bits,
    output cplx_t      o_sym
);

`ifdef SOML_ENC_POWER_NORM_EN
    localparam longint c_L1_BASE = longint'(c_LVL1_NORM);
    localparam longint c_L3_BASE = longint'(c_LVL3_NORM);
`else
    localparam longint c_L1_BASE = longint'(c_LVL1_UNIT);
    localparam longint c_L3_BASE = longint'(c_LVL3_UNIT);
`endif

    // Package levels are Q22; rescale to the configured fraction width.
    localparam longint c_L1_Q = (c_L1_BASE <<< Q) >>> c_Q;
    localparam longint c_L3_Q = (c_L3_BASE <<< Q) >>> c_Q;
    localparam logic signed [c_N-1:0] c_L1 = c_N'(c_L1_Q);
    localparam logic signed [c_N-1:0] c_L3 = c_N'(c_L3_Q);

    // Independent PAM-4 mapping of the in-phase and quadrature fields.
    always_comb begin
        o_sym.r = pam4_level(i_bits[3:2], c_L1, c_L3);
        o_sym.i = pam4_level(i_bits[1:0], c_L1, c_L3);
    end

endmodule
`default_nettype wire

// File: rtl/soml_stbc_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : soml_stbc_encoder
//  Description : Maps a 12-bit information word to a 4-antenna x 2-slot
//                Alamouti codeword (pair select, rotation, two 16-QAM
//                symbols) and streams it as 8 complex samples, slot-major.
//                Optional level normalisation: SOML_ENC_POWER_NORM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module soml_stbc_encoder
    import soml_pkg::*;
#(
    parameter int Q = 22,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bits_valid,
    input  logic [11:0]  bits_in,
    output logic         bits_ready,
    output logic         X_out_valid,
    input  logic         X_out_ready,
    output logic [N-1:0] X_out_r,
    output logic [N-1:0] X_out_i,
    output logic [1:0]   X_out_ant,
    output logic         X_out_slot,
    output logic         X_out_last
);

    state_t      r_state;
    logic [11:0] r_word;
    logic [2:0]  r_k;
    cplx_t       r_buf [8];

    cplx_t w_s1;
    cplx_t w_s2;
    cplx_t w_s2r;
    cplx_t w_sel;
    cplx_t w_code [8];
    pair_t w_pair;

    soml_qam16_mapper #(.Q(Q)) u_map_s1 (
        .i_bits (r_word[7:4]),
        .o_sym  (w_s1)
    );

    soml_qam16_mapper #(.Q(Q)) u_map_s2 (
        .i_bits (r_word[3:0]),
        .o_sym  (w_s2)
    );

    assign w_pair = pair_lookup(r_word[11:10]);

    // Rotate s2 by j^r; each step by j maps (x, y) to (-y, x).
    always_comb begin
        w_s2r = w_s2;
        case (r_word[9:8])
            2'd1:    begin w_s2r.r = -w_s2.i; w_s2r.i =  w_s2.r; end
            2'd2:    begin w_s2r.r = -w_s2.r; w_s2r.i = -w_s2.i; end
            2'd3:    begin w_s2r.r =  w_s2.i; w_s2r.i = -w_s2.r; end
            default: w_s2r = w_s2;
        endcase
    end

    // Place the Alamouti pair on the selected antennas; index is {slot, ant}.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_code[k] = '0;
        end
        w_code[{1'b0, w_pair.ant_a}]   = w_s1;
        w_code[{1'b0, w_pair.ant_b}]   = w_s2r;
        w_code[{1'b1, w_pair.ant_a}].r = -w_s2r.r;
        w_code[{1'b1, w_pair.ant_a}].i =  w_s2r.i;
        w_code[{1'b1, w_pair.ant_b}].r =  w_s1.r;
        w_code[{1'b1, w_pair.ant_b}].i = -w_s1.i;
    end

    // Control FSM: accept a word, latch the codeword, stream 8 samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_word  <= '0;
            r_k     <= '0;
            for (int k = 0; k < 8; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bits_valid) begin
                        r_word  <= bits_in;
                        r_state <= c_ST_MAP;
                    end
                end
                c_ST_MAP: begin
                    r_buf   <= w_code;
                    r_k     <= '0;
                    r_state <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (X_out_ready) begin
                        if (r_k == 3'd7) begin
                            r_k     <= '0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Output view of the buffer entry addressed by k; data forced to zero
    // when no sample is being presented.
    always_comb begin
        w_sel       = r_buf[r_k];
        bits_ready  = (r_state == c_ST_IDLE) && !rst;
        X_out_valid = (r_state == c_ST_SEND);
        X_out_r     = X_out_valid ? N'(w_sel.r) : '0;
        X_out_i     = X_out_valid ? N'(w_sel.i) : '0;
        X_out_ant   = r_k[1:0];
        X_out_slot  = r_k[2];
        X_out_last  = X_out_valid && (r_k == 3'd7);
    end

endmodule
`default_nettype wire

// File: tb/tb_soml_stbc_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soml_stbc_encoder
//  Description : Scoreboard bench for soml_stbc_encoder. Expected samples
//                come from hand-computed level tables; a negedge monitor
//                pops and compares every accepted sample.
//                Honours SOML_ENC_POWER_NORM_EN for the level values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soml_stbc_encoder;

`ifdef SOML_ENC_POWER_NORM_EN
    localparam longint c_L1 = 1326355;
    localparam longint c_L3 = 3979065;
`else
    localparam longint c_L1 = 4194304;
    localparam longint c_L3 = 12582912;
`endif

    typedef struct {
        longint r;
        longint i;
        int     ant;
        int     slot;
        int     last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               bits_valid = 1'b0;
    logic [11:0]        bits_in = '0;
    logic               bits_ready;
    logic               X_out_valid;
    logic               X_out_ready = 1'b1;
    logic signed [31:0] X_out_r;
    logic signed [31:0] X_out_i;
    logic [1:0]         X_out_ant;
    logic               X_out_slot;
    logic               X_out_last;

    // Level multipliers per sample k = slot*4 + ant, as (r, i) pairs.
    // 0:000  1:4FF  2:1AA  3:A1E (pair(0,2), r=2)  4:F78 (pair(1,3), r=3)
    int tab [5][16] = '{
        '{-3,-3, -3,-3,  0, 0,  0, 0,   3,-3, -3, 3,  0, 0,  0, 0},
        '{ 0, 0,  0, 0,  1, 1,  1, 1,   0, 0,  0, 0, -1, 1,  1,-1},
        '{ 3, 3, -3, 3,  0, 0,  0, 0,   3, 3,  3,-3,  0, 0,  0, 0},
        '{-3,-1,  0, 0, -1,-3,  0, 0,   1,-3,  0, 0, -3, 1,  0, 0},
        '{ 0, 0, -1, 1,  0, 0, -3,-3,   0, 0,  3,-3,  0, 0, -1,-1}
    };

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_acc    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   last_cyc = -100;
    bit   chk_lat  = 1'b0;
    bit   tog_en   = 1'b0;

    soml_stbc_encoder #(.Q(22), .N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bits_valid  (bits_valid),
        .bits_in     (bits_in),
        .bits_ready  (bits_ready),
        .X_out_valid (X_out_valid),
        .X_out_ready (X_out_ready),
        .X_out_r     (X_out_r),
        .X_out_i     (X_out_i),
        .X_out_ant   (X_out_ant),
        .X_out_slot  (X_out_slot),
        .X_out_last  (X_out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint lv(input int m);
        case (m)
            -3:      return -c_L3;
            -1:      return -c_L1;
            1:       return c_L1;
            3:       return c_L3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic push_frame(input int fi);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.r    = lv(tab[fi][2*k]);
            e.i    = lv(tab[fi][2*k+1]);
            e.ant  = k % 4;
            e.slot = k / 4;
            e.last = (k == 7) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    // Present a word and hold it until it is taken; optionally check the
    // idle gap between the previous frame's last sample and this accept.
    task automatic send_word(input logic [11:0] w, input int fi, input bit chk_gap);
        bit got = 1'b0;
        push_frame(fi);
        bits_in    = w;
        bits_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bits_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bits_valid = 1'b0;
        acc_cyc    = cyc;
        if (!got) check(1'b0, "accept_timeout", 0, 1);
        if (chk_gap) check((acc_cyc - last_cyc) == 2, "next_accept_gap", acc_cyc - last_cyc, 2);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !X_out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(done, "drain_timeout", sb.size(), 0);
    endtask

    // Ready toggler for the backpressure scenario.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) X_out_ready = ~X_out_ready;
        end
    end

    // Monitor: compare each accepted sample, and stall stability.
    exp_t               m_e;
    bit                 m_ok;
    bit                 stall_pend = 1'b0;
    logic signed [31:0] sv_r, sv_i;
    logic [1:0]         sv_ant;
    logic               sv_slot, sv_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                stall_pend = 1'b0;
                m_ok = X_out_valid && X_out_r == sv_r && X_out_i == sv_i &&
                       X_out_ant == sv_ant && X_out_slot == sv_slot && X_out_last == sv_last;
                check(m_ok, "stall_hold_r", X_out_r, sv_r);
            end
            if (X_out_valid) check(!bits_ready, "bits_ready_in_frame", bits_ready, 0);
            if (X_out_valid && X_out_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_sample_r", X_out_r, 0);
                end else begin
                    m_e = sb.pop_front();
                    m_ok = (X_out_r == m_e.r) && (X_out_i == m_e.i) &&
                           (int'(X_out_ant) == m_e.ant) && (int'(X_out_slot) == m_e.slot) &&
                           (int'(X_out_last) == m_e.last);
                    n_checks++;
                    if (m_ok) n_pass++;
                    else $display("FAIL sample slot%0d ant%0d: got r=%0d i=%0d ant=%0d slot=%0d last=%0d, expected r=%0d i=%0d ant=%0d slot=%0d last=%0d",
                                  m_e.slot, m_e.ant, X_out_r, X_out_i, X_out_ant, X_out_slot, X_out_last,
                                  m_e.r, m_e.i, m_e.ant, m_e.slot, m_e.last);
                    if (m_e.ant == 0 && m_e.slot == 0 && chk_lat)
                        check((cyc - acc_cyc) == 1, "first_sample_latency", cyc - acc_cyc, 1);
                end
                if (X_out_last) last_cyc = cyc;
                n_acc++;
            end else if (X_out_valid) begin
                sv_r       = X_out_r;
                sv_i       = X_out_i;
                sv_ant     = X_out_ant;
                sv_slot    = X_out_slot;
                sv_last    = X_out_last;
                stall_pend = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

    // Stimulus sequence.
    initial begin
        int base;
        bit hit;
        repeat (3) @(negedge clk);
        check(bits_ready == 1'b0, "bits_ready_during_reset", bits_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check(bits_ready == 1'b1, "reset_bits_ready", bits_ready, 1);
        check(X_out_valid == 1'b0, "reset_valid", X_out_valid, 0);
        check(X_out_r == 0, "reset_r", X_out_r, 0);
        check(X_out_i == 0, "reset_i", X_out_i, 0);
        check(X_out_ant == 2'd0, "reset_ant", X_out_ant, 0);
        check(X_out_slot == 1'b0, "reset_slot", X_out_slot, 0);
        check(X_out_last == 1'b0, "reset_last", X_out_last, 0);

        // Back-to-back frames, ready held high, next word waiting early.
        chk_lat = 1'b1;
        @(posedge clk);
        #1;
        send_word(12'h000, 0, 1'b0);
        send_word(12'h4FF, 1, 1'b1);
        send_word(12'h1AA, 2, 1'b1);
        send_word(12'hA1E, 3, 1'b1);
        send_word(12'hF78, 4, 1'b1);
        wait_drain();

        // Backpressure: ready toggles every cycle.
        chk_lat = 1'b0;
        tog_en  = 1'b1;
        send_word(12'hA1E, 3, 1'b0);
        wait_drain();
        tog_en = 1'b0;
        @(posedge clk);
        #1;
        X_out_ready = 1'b1;

        // Reset after sample k=3 has been accepted.
        chk_lat = 1'b1;
        base = n_acc;
        send_word(12'h000, 0, 1'b0);
        hit = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #2;
            if (n_acc >= base + 4) begin
                hit = 1'b1;
                break;
            end
        end
        check(hit, "reach_k3_timeout", n_acc - base, 4);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check(X_out_valid == 1'b0, "abort_valid", X_out_valid, 0);
        check(X_out_r == 0 && X_out_i == 0, "abort_data_r", X_out_r, 0);
        check(X_out_last == 1'b0, "abort_last", X_out_last, 0);
        rst = 1'b0;
        @(negedge clk);
        check(bits_ready == 1'b1, "abort_bits_ready", bits_ready, 1);
        @(posedge clk);
        #1;
        send_word(12'hF78, 4, 1'b0);
        wait_drain();

        check(n_acc == 60, "total_samples", n_acc, 60);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
